regex_cpu_memory_arbiter: RTL
=============================

# regex_cpu_memory_arbiter

Round-robin arbiter that shares one single-port instruction memory between `N_CPUS` regex_cpu instances. Each CPU keeps its existing memory handshake: `memory_valid`/`memory_addr` out, `memory_ready`/`memory_data` in. The arbiter serialises those requests onto a BRAM port with 1-cycle read latency and returns each word to the requesting CPU only. It sits between the CPU array and the instruction BRAM. It is fully pipelined and accepts one grant per cycle across different requesters.

## Interface
- `N_CPUS`, 4, number of requesting regex_cpu instances (≥2)
- `MEMORY_WIDTH`, 20, instruction word width
- `MEMORY_ADDR_WIDTH`, 11, instruction memory address width

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `cpu_memory_valid`  in  N_CPUS  per-CPU read request; held until served
- `cpu_memory_addr`  in  N_CPUS*MEMORY_ADDR_WIDTH  per-CPU request address; slice i = CPU i
- `cpu_memory_ready`  out  N_CPUS  per-CPU grant pulse, registered
- `cpu_memory_data`  out  N_CPUS*MEMORY_WIDTH  per-CPU returned word, registered, held between grants
- `bram_en`  out  1  BRAM read enable, registered
- `bram_addr`  out  MEMORY_ADDR_WIDTH  BRAM read address, registered
- `bram_rdata`  in  MEMORY_WIDTH  BRAM read data, valid 1 cycle after the edge that samples `bram_en`

## Operation
- Eligible vector: `elig = cpu_memory_valid & ~mask`.
- Round-robin selection:
  - Pointer `last` holds the index of the most recent grant.
  - Search starts at `last+1` and wraps modulo `N_CPUS`.
  - The first eligible index wins.
- On an edge with any `elig` bit set, and winner w:
  - Register `cpu_memory_ready = onehot(w)`.
  - Register `bram_en = 1` and `bram_addr = addr slice w`.
  - Set `last = w` and set `mask[w]`.
- On an edge with no eligible request:
  - `cpu_memory_ready = 0` and `bram_en = 0`.
  - `bram_addr` holds its last value.
- Mask per requester:
  - A 2-bit countdown, loaded to 2 on grant and decremented each edge.
  - `mask[i] = (count_i != 0)`.
  - This covers the stale `memory_valid` that a CPU still shows on the edge after its ready pulse.
- Return pipeline:
  - A tag register carries w alongside `bram_en` for 1 stage.
  - One edge after BRAM samples, `bram_rdata` is written into `cpu_memory_data` slice w.
  - All other slices are unchanged.
- At most one outstanding BRAM read per cycle. No request queueing beyond the CPU's held `valid`.
- Requests are never dropped. A CPU holding `valid` is granted within `N_CPUS` cycles of becoming eligible.

## Timing
- Reset (`rst == 0` at an edge) clears:
  - `cpu_memory_ready`, `bram_en`, `bram_addr` and all `cpu_memory_data` slices to 0.
  - All masks and the return-stage valid.
  - `last` is set to `N_CPUS-1`, so CPU0 has first priority.
- Reset mid-read: the in-flight BRAM result is discarded and no data register is written. Requests still held after reset release are re-arbitrated from scratch.
- Grant at edge k (`ready[w]` and `bram_en` high during cycle k..k+1):
  - BRAM samples the address at edge k+1.
  - `cpu_memory_data[w]` is updated at edge k+2 and is stable from k+2 until the next grant to w.
- Request-to-grant latency:
  - An eligible request present before edge k and winning arbitration gives ready high after edge k.
  - Minimum 1 cycle.
- Throughput:
  - 1 grant/cycle when requests come from different CPUs.
  - Same CPU is re-grantable no earlier than 3 edges after its previous grant.
- `cpu_memory_ready` is high for exactly 1 cycle per grant and is never high for two CPUs in the same cycle.
- Simultaneous requests: order is strictly round-robin from `last+1`. A newly arriving request never preempts an earlier-indexed winner for that edge.
- Wrap-around: `last = N_CPUS-1` searches from 0.

## Test plan
- **Single request.** After reset, CPU2 holds `valid` with addr 0x062; BRAM[0x062] = 0x1A5C3.
  - `ready[2]` pulses 1 cycle; `bram_addr = 0x062` with `bram_en = 1`.
  - Slice 2 of `cpu_memory_data` = 0x1A5C3 two edges after the ready edge; other slices stay 0.
  - No second `ready[2]` while `valid` drops.
- **All request at once.** CPUs 0..3 assert `valid` simultaneously with addrs 0x10..0x13 after reset.
  - Grants on 4 consecutive cycles in order 0, 1, 2, 3.
  - Each data slice holds BRAM[0x10+i].
  - `bram_en` is high for exactly 4 cycles.
- **Fairness.** CPU0 and CPU3 re-request immediately after every data return for 40 cycles.
  - Grants alternate 0, 3, 0, 3…
  - Neither CPU is granted twice without the other being granted in between.
- **Stale valid.** CPU1 keeps `valid` high continuously, addr 0x108.
  - `ready[1]` pulses every 3rd cycle exactly, never on adjacent or every-other cycles.
  - Data is always BRAM[0x108].
- **Reset mid-read.** CPU0 is granted at edge k; `rst = 0` at edge k+1, released at k+2.
  - Slice 0 of data reads 0 after reset; no ready seen during reset.
  - If CPU0 still holds `valid`, it is regranted on the first edge after release.
- **Idle.** No `valid` for 50 cycles after reset.
  - `bram_en`, `cpu_memory_ready` and `bram_addr` stay 0 throughout.

Source files
------------

// File: rtl/regex_cpu_memory_arbiter_if.sv
// Bus bundle between the regex_cpu array, the arbiter and the instruction BRAM.
//
// Handshake: a CPU raises cpu_memory_valid[i] with its address slice and holds
// both until it sees a one-cycle cpu_memory_ready[i] pulse. The returned word is
// written into cpu_memory_data slice i two edges after that pulse and is held
// until the next grant to the same CPU. The BRAM side is a plain read port:
// bram_en/bram_addr sampled on an edge, bram_rdata valid one cycle later.
interface regex_cpu_memory_arbiter_if #(
  parameter int N_CPUS            = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic [N_CPUS-1:0]                   cpu_memory_valid;
  logic [N_CPUS*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr;
  logic [N_CPUS-1:0]                   cpu_memory_ready;
  logic [N_CPUS*MEMORY_WIDTH-1:0]      cpu_memory_data;
  logic                                bram_en;
  logic [MEMORY_ADDR_WIDTH-1:0]        bram_addr;
  logic [MEMORY_WIDTH-1:0]             bram_rdata;

  // Arbiter view
  modport slave (
    input  cpu_memory_valid,
    input  cpu_memory_addr,
    input  bram_rdata,
    output cpu_memory_ready,
    output cpu_memory_data,
    output bram_en,
    output bram_addr
  );

  // CPU array + BRAM view
  modport master (
    output cpu_memory_valid,
    output cpu_memory_addr,
    output bram_rdata,
    input  cpu_memory_ready,
    input  cpu_memory_data,
    input  bram_en,
    input  bram_addr
  );
endinterface

// File: rtl/regex_cpu_memory_arbiter.sv
// Round-robin arbiter sharing one single-port instruction BRAM among N_CPUS
// regex_cpu instances. One grant per cycle; each CPU is masked for two edges
// after a grant so its stale valid (still high on the edge after ready) is
// not re-granted. Read data is steered back to the requesting CPU only.
module regex_cpu_memory_arbiter #(
  parameter int N_CPUS            = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input logic                        clk,
  input logic                        rst,
  regex_cpu_memory_arbiter_if.slave  io_mem
);

  localparam int IDX_W = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;
  localparam int AW    = MEMORY_ADDR_WIDTH;
  localparam int DW    = MEMORY_WIDTH;

  // Arbitration state
  logic [IDX_W-1:0]        r_last;
  logic [1:0]              r_cnt [N_CPUS];

  // Issue stage (registered outputs toward CPUs and BRAM)
  logic [N_CPUS-1:0]       r_ready;
  logic                    r_bram_en;
  logic [AW-1:0]           r_bram_addr;
  logic [IDX_W-1:0]        r_tag;

  // Return stage: BRAM has sampled, data arrives this cycle
  logic                    r_ret_valid;
  logic [IDX_W-1:0]        r_ret_tag;
  logic [N_CPUS*DW-1:0]    r_data;

  logic [N_CPUS-1:0]       w_mask;
  logic [N_CPUS-1:0]       w_elig;
  logic                    w_any;
  logic [IDX_W-1:0]        w_win;
  logic [N_CPUS-1:0]       w_grant;

  // A requester is masked while its post-grant countdown is non-zero
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_CPUS; i++) begin
      w_mask[i] = (r_cnt[i] != 2'd0);
    end
  end

  assign w_elig = io_mem.cpu_memory_valid & ~w_mask;

  // Round-robin search starting one past the last winner, wrapping at N_CPUS
  always_comb begin
    int v_idx;
    v_idx = 0;
    w_any = 1'b0;
    w_win = r_last;
    for (int off = 1; off <= N_CPUS; off++) begin
      v_idx = int'(r_last) + off;
      if (v_idx >= N_CPUS) v_idx = v_idx - N_CPUS;
      if (!w_any && w_elig[v_idx[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = v_idx[IDX_W-1:0];
      end
    end
  end

  // One-hot form of the winner, empty when nobody is eligible
  always_comb begin
    w_grant = '0;
    if (w_any) w_grant[w_win] = 1'b1;
  end

  // Round-robin pointer; reset points at the last CPU so CPU0 wins first
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= IDX_W'(N_CPUS - 1);
    end else if (w_any) begin
      r_last <= w_win;
    end
  end

  // Per-CPU countdown: loaded to 2 on grant, drains by one per edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CPUS; i++) begin
      if (!rst) begin
        r_cnt[i] <= 2'd0;
      end else if (w_grant[i]) begin
        r_cnt[i] <= 2'd2;
      end else if (r_cnt[i] != 2'd0) begin
        r_cnt[i] <= r_cnt[i] - 2'd1;
      end
    end
  end

  // Issue stage: ready pulse, BRAM read request and its return tag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready     <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_tag       <= '0;
    end else begin
      r_ready   <= w_grant;
      r_bram_en <= w_any;
      if (w_any) begin
        r_bram_addr <= io_mem.cpu_memory_addr[int'(w_win)*AW +: AW];
        r_tag       <= w_win;
      end
    end
  end

  // Return tracking: the edge after issue is when BRAM samples the address
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ret_valid <= 1'b0;
      r_ret_tag   <= '0;
    end else begin
      r_ret_valid <= r_bram_en;
      r_ret_tag   <= r_tag;
    end
  end

  // Write returning word into the requester's slice only; a reset in flight
  // clears r_ret_valid so the discarded read never lands
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
    end else if (r_ret_valid) begin
      r_data[int'(r_ret_tag)*DW +: DW] <= io_mem.bram_rdata;
    end
  end

  assign io_mem.cpu_memory_ready = r_ready;
  assign io_mem.cpu_memory_data  = r_data;
  assign io_mem.bram_en          = r_bram_en;
  assign io_mem.bram_addr        = r_bram_addr;

endmodule
